// File: rtl/dbg_mem_sequencer.sv
// Command-driven load/run/dump sequencer for the RV32Core BRAM debug ports.
// Optional running checksum of streamed words: define DBG_SEQ_CHECKSUM_EN.
module dbg_mem_sequencer #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4096,
    parameter int RD_LAT     = 2,
    parameter int RST_CYCLES = 5,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         CPU_CLK,
    input  logic                         CPU_RST_N,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [CH_W-1:0]              cmd_ch,
    input  logic [31:0]                  cmd_len,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [DATA_W-1:0]            ld_data,
    output logic                         du_valid,
    input  logic                         du_ready,
    output logic [DATA_W-1:0]            du_data,
    output logic [31:0]                  du_addr,
    output logic                         du_last,
    output logic [NUM_CH*32-1:0]         dbg_a2,
    output logic [NUM_CH*DATA_W-1:0]     dbg_wd2,
    output logic [NUM_CH*(DATA_W/8)-1:0] dbg_we2,
    input  logic [NUM_CH*DATA_W-1:0]     dbg_rd2,
    output logic                         core_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  checksum
);

    localparam int          BW      = DATA_W / 8;
    localparam logic [31:0] BYTES_W = 32'(BW);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [1:0]  OP_LOAD = 2'd0;
    localparam logic [1:0]  OP_DUMP = 2'd1;
    localparam logic [1:0]  OP_RUN  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DUMP_ADDR, S_DUMP_WAIT, S_DUMP_OUT, S_RUN_RST, S_RUN_EXEC, S_FIN
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [31:0]         len_q, idx_q, cnt_q, a2_q, du_addr_q;
    logic [DATA_W-1:0]   wd2_q, du_data_q;
    logic [NUM_CH-1:0]   we_q;
    logic                du_valid_q, du_last_q, core_rst_q, done_q, err_q;

    logic                cmdFire, ldFire, duFire, badCh_d;
    logic [31:0]         effLen_d, nextIdx_d, byteAddr_d, nextAddr_d;
    logic [NUM_CH-1:0]   chHot_d;
    logic [DATA_W-1:0]   rdSel_d;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ld_ready   = (state_q == S_LOAD) && (idx_q != len_q);
    assign cmdFire    = cmd_valid && cmd_ready;
    assign ldFire     = ld_valid && ld_ready;
    assign duFire     = du_valid_q && du_ready;
    assign badCh_d    = (32'(cmd_ch) >= 32'(NUM_CH));
    assign effLen_d   = (cmd_len > DEPTH_W) ? DEPTH_W : cmd_len;
    assign nextIdx_d  = idx_q + 32'd1;
    assign byteAddr_d = idx_q * BYTES_W;
    assign nextAddr_d = nextIdx_d * BYTES_W;

    always_comb begin
        chHot_d = '0;
        rdSel_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                chHot_d[c] = 1'b1;
                rdSel_d    = dbg_rd2[c*DATA_W +: DATA_W];
            end
        end
    end

    // Address and data are broadcast; only the write enable is steered per channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign dbg_a2[c*32 +: 32]         = a2_q;
        assign dbg_wd2[c*DATA_W +: DATA_W] = wd2_q;
        assign dbg_we2[c*BW +: BW]        = {BW{we_q[c]}};
    end

    assign du_valid = du_valid_q;
    assign du_data  = du_data_q;
    assign du_addr  = du_addr_q;
    assign du_last  = du_last_q;
    assign core_rst = core_rst_q;
    assign done     = done_q;
    assign err      = err_q;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            a2_q       <= '0;
            wd2_q      <= '0;
            we_q       <= '0;
            du_valid_q <= 1'b0;
            du_data_q  <= '0;
            du_addr_q  <= '0;
            du_last_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmdFire) begin
                        ch_q  <= cmd_ch;
                        idx_q <= '0;
                        if (cmd_op == OP_LOAD || cmd_op == OP_DUMP) begin
                            if (badCh_d || cmd_len == 32'd0) begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                                err_q   <= badCh_d;
                            end else begin
                                len_q <= effLen_d;
                                if (cmd_op == OP_LOAD) begin
                                    state_q <= S_LOAD;
                                end else begin
                                    a2_q    <= '0;
                                    state_q <= S_DUMP_ADDR;
                                end
                            end
                        end else if (cmd_op == OP_RUN) begin
                            len_q   <= cmd_len;
                            cnt_q   <= 32'(RST_CYCLES - 1);
                            state_q <= S_RUN_RST;
                        end else begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                // Leaving only once every word is issued keeps the last WE cycle before FIN.
                S_LOAD: begin
                    if (idx_q == len_q) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else if (ldFire) begin
                        a2_q  <= byteAddr_d;
                        wd2_q <= ld_data;
                        we_q  <= chHot_d;
                        idx_q <= nextIdx_d;
                    end
                end
                S_DUMP_ADDR: begin
                    cnt_q   <= 32'(RD_LAT - 1);
                    state_q <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: begin
                    if (cnt_q == 32'd0) begin
                        du_data_q  <= rdSel_d;
                        du_addr_q  <= byteAddr_d;
                        du_last_q  <= (nextIdx_d == len_q);
                        du_valid_q <= 1'b1;
                        state_q    <= S_DUMP_OUT;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_DUMP_OUT: begin
                    if (duFire) begin
                        du_valid_q <= 1'b0;
                        du_last_q  <= 1'b0;
                        if (du_last_q) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= nextIdx_d;
                            a2_q    <= nextAddr_d;
                            state_q <= S_DUMP_ADDR;
                        end
                    end
                end
                S_RUN_RST: begin
                    if (cnt_q != 32'd0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else if (len_q == 32'd0) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q      <= len_q - 32'd1;
                        core_rst_q <= 1'b0;
                        state_q    <= S_RUN_EXEC;
                    end
                end
                // Counting down from len-1 lets a full 32-bit run length complete without wrap.
                S_RUN_EXEC: begin
                    if (cnt_q == 32'd0) begin
                        core_rst_q <= 1'b1;
                        state_q    <= S_FIN;
                        done_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DBG_SEQ_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            checksum_q <= '0;
        end else if (cmdFire && (cmd_op == OP_LOAD || cmd_op == OP_DUMP)) begin
            checksum_q <= '0;
        end else if (ldFire) begin
            checksum_q <= checksum_q + 32'(ld_data);
        end else if (duFire) begin
            checksum_q <= checksum_q + 32'(du_data_q);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dbg_mem_sequencer.sv
// Directed self-checking bench for dbg_mem_sequencer with a two-channel BRAM model
// whose read data appears two cycles after the debug address changes.
module tb_dbg_mem_sequencer;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int CH_W   = 2;

`ifdef DBG_SEQ_CHECKSUM_EN
    localparam logic [31:0] CSUM_A = 32'h66;
    localparam logic [31:0] CSUM_B = 32'h99;
`else
    localparam logic [31:0] CSUM_A = 32'h0;
    localparam logic [31:0] CSUM_B = 32'h0;
`endif

    logic                     CPU_CLK = 1'b0;
    logic                     CPU_RST_N;
    logic                     cmd_valid, cmd_ready;
    logic [1:0]               cmd_op;
    logic [CH_W-1:0]          cmd_ch;
    logic [31:0]              cmd_len;
    logic                     ld_valid, ld_ready;
    logic [DATA_W-1:0]        ld_data;
    logic                     du_valid, du_ready, du_last;
    logic [DATA_W-1:0]        du_data;
    logic [31:0]              du_addr;
    logic [NUM_CH*32-1:0]     dbg_a2;
    logic [NUM_CH*DATA_W-1:0] dbg_wd2, dbg_rd2;
    logic [NUM_CH*4-1:0]      dbg_we2;
    logic                     core_rst, busy, done, err;
    logic [31:0]              checksum;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [NUM_CH][4096];
    logic [31:0] p1 [NUM_CH];
    logic [31:0] p2 [NUM_CH];
    logic [31:0] loadData [3];

    always #5 CPU_CLK = ~CPU_CLK;

    dbg_mem_sequencer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(4096), .RD_LAT(2), .RST_CYCLES(5), .CH_W(CH_W)
    ) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .du_valid(du_valid), .du_ready(du_ready), .du_data(du_data), .du_addr(du_addr), .du_last(du_last),
        .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    // BRAM model: writes on full WE, read data valid two edges after the address changes.
    always @(posedge CPU_CLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (dbg_we2[c*4 +: 4] == 4'hF) mem[c][dbg_a2[c*32+2 +: 12]] <= dbg_wd2[c*32 +: 32];
            p1[c] <= mem[c][dbg_a2[c*32+2 +: 12]];
            p2[c] <= p1[c];
        end
    end
    assign dbg_rd2 = {p2[1], p2[0]};

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [CH_W-1:0] ch, input logic [31:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
    endtask

    task automatic waitDuValid(input int maxCycles);
        int n = 0;
        while (!du_valid && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("duValidSeen", 32'(du_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int doneSeen;
        loadData  = '{32'h11, 32'h22, 32'h33};
        CPU_RST_N = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd3; cmd_ch = '0; cmd_len = '0;
        ld_valid  = 1'b0; ld_data = '0; du_ready = 1'b0;
        tick(); tick();
        CPU_RST_N = 1'b1;
        tick();
        checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstCoreRst", 32'(core_rst), 32'd1);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstWe", 32'(dbg_we2), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);

        $display("[TB] LOAD ch0 of three words");
        applyStimulus(2'd0, 2'd0, 32'd3);
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = loadData[i];
            checkOutput("ldReady", 32'(ld_ready), 32'd1);
            tick();
            checkOutput("loadWe", 32'(dbg_we2), 32'h0F);
            checkOutput("loadA2", dbg_a2[31:0], 32'(i * 4));
            checkOutput("loadWd", dbg_wd2[31:0], loadData[i]);
            checkOutput("loadNoDone", 32'(done), 32'd0);
        end
        ld_valid = 1'b0;
        checkOutput("ldReadyEnd", 32'(ld_ready), 32'd0);
        tick();
        checkOutput("loadDone", 32'(done), 32'd1);
        checkOutput("loadWeOff", 32'(dbg_we2), 32'd0);
        checkOutput("loadErr", 32'(err), 32'd0);
        tick();
        checkOutput("loadDoneOnce", 32'(done), 32'd0);
        checkOutput("loadIdle", 32'(cmd_ready), 32'd1);
        checkOutput("loadChecksum", checksum, CSUM_A);

        $display("[TB] DUMP ch0 with back-pressure on the first word");
        applyStimulus(2'd1, 2'd0, 32'd3);
        checkOutput("dumpBusy", 32'(busy), 32'd1);
        tick(); tick();
        checkOutput("dumpLatency", 32'(du_valid), 32'd0);
        tick();
        checkOutput("dumpFirstValid", 32'(du_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("dumpHoldData", du_data, 32'h11);
            checkOutput("dumpHoldValid", 32'(du_valid), 32'd1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) waitDuValid(10);
            checkOutput("dumpData", du_data, loadData[i]);
            checkOutput("dumpAddr", du_addr, 32'(i * 4));
            checkOutput("dumpLast", 32'(du_last), (i == 2) ? 32'd1 : 32'd0);
            checkOutput("dumpWe", 32'(dbg_we2), 32'd0);
            du_ready = 1'b1;
            tick();
            du_ready = 1'b0;
        end
        checkOutput("dumpDone", 32'(done), 32'd1);
        checkOutput("dumpValidOff", 32'(du_valid), 32'd0);
        checkOutput("dumpChecksum", checksum, CSUM_A);
        tick();

        $display("[TB] RUN for 100 cycles");
        applyStimulus(2'd2, 2'd0, 32'd100);
        n = 0;
        while (core_rst && n < 50) begin n++; tick(); end
        checkOutput("runRstCycles", 32'(n), 32'd5);
        n = 0;
        doneSeen = 0;
        while (!core_rst && n < 1000) begin
            if (done) doneSeen++;
            n++;
            tick();
        end
        checkOutput("runExecCycles", 32'(n), 32'd100);
        checkOutput("runEarlyDone", 32'(doneSeen), 32'd0);
        checkOutput("runDone", 32'(done), 32'd1);
        tick();
        checkOutput("runDoneOnce", 32'(done), 32'd0);
        checkOutput("runCoreRst", 32'(core_rst), 32'd1);

        $display("[TB] bad channel, NOP and zero length");
        applyStimulus(2'd0, 2'd2, 32'd3);
        checkOutput("badDone", 32'(done), 32'd1);
        checkOutput("badErr", 32'(err), 32'd1);
        checkOutput("badWe", 32'(dbg_we2), 32'd0);
        checkOutput("badLdReady", 32'(ld_ready), 32'd0);
        tick();
        checkOutput("badErrOnce", 32'(err), 32'd0);
        applyStimulus(2'd3, 2'd0, 32'd7);
        checkOutput("nopDone", 32'(done), 32'd1);
        checkOutput("nopErr", 32'(err), 32'd0);
        tick();
        applyStimulus(2'd0, 2'd1, 32'd0);
        checkOutput("zeroLenDone", 32'(done), 32'd1);
        checkOutput("zeroLenErr", 32'(err), 32'd0);
        tick();

        $display("[TB] reset abort during second dump word");
        applyStimulus(2'd1, 2'd0, 32'd3);
        waitDuValid(10);
        du_ready = 1'b1;
        tick();
        du_ready = 1'b0;
        waitDuValid(10);
        checkOutput("abortWord2", du_data, 32'h22);
        CPU_RST_N = 1'b0;
        #1;
        checkOutput("abortValid", 32'(du_valid), 32'd0);
        checkOutput("abortCoreRst", 32'(core_rst), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        tick();
        CPU_RST_N = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) doneSeen++;
            tick();
        end
        checkOutput("abortNoDone", 32'(doneSeen), 32'd0);

        $display("[TB] LOAD ch1 after abort");
        applyStimulus(2'd0, 2'd1, 32'd2);
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data = (i == 0) ? 32'h44 : 32'h55;
            tick();
            checkOutput("load1We", 32'(dbg_we2), 32'hF0);
            checkOutput("load1A2", dbg_a2[63:32], 32'(i * 4));
            checkOutput("load1Wd", dbg_wd2[63:32], (i == 0) ? 32'h44 : 32'h55);
        end
        ld_valid = 1'b0;
        tick();
        checkOutput("load1Done", 32'(done), 32'd1);
        checkOutput("load1Checksum", checksum, CSUM_B);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_mem_sequencer.md
Name: dbg_mem_sequencer

Overview:
- Synthesizable sequencer for the RV32Core BRAM debug ports (A2/WD2/WE2/RD2).
- Generalises the load/run/dump flow to NUM_CH memories of parametrised width and depth.
- Driven by a command interface: LOAD a stream into a channel, RUN the core for N cycles, DUMP a channel out as a stream.
- Sits between a host link (UART/JTAG bridge) and the core; also owns the core's reset.

Parameters:
- NUM_CH, 2, number of debug-port memories (ch0 = DataRAM, ch1 = InstRAM).
- DATA_W, 32, word width; multiple of 8.
- DEPTH, 4096, words per memory.
- RD_LAT, 2, debug read latency in cycles from A2 change to valid RD2; must be ≥1.
- RST_CYCLES, 5, core reset pulse length at RUN start; must be ≥1.
- CH_W, $clog2(NUM_CH) (min 1), channel index width.

Ports:
- CPU_CLK  in  1  clock.
- CPU_RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0=LOAD, 1=DUMP, 2=RUN, 3=NOP.
- cmd_ch  in  CH_W  target channel (LOAD/DUMP).
- cmd_len  in  32  word count (LOAD/DUMP) or run cycles (RUN).
- ld_valid / ld_ready  in/out  1  load stream handshake.
- ld_data  in  DATA_W  load word.
- du_valid / du_ready  out/in  1  dump stream handshake.
- du_data  out  DATA_W  dumped word.
- du_addr  out  32  byte address of du_data.
- du_last  out  1  final dump word.
- dbg_a2  out  NUM_CH*32  per-channel debug byte address.
- dbg_wd2  out  NUM_CH*DATA_W  per-channel write data.
- dbg_we2  out  NUM_CH*(DATA_W/8)  per-channel byte write enables.
- dbg_rd2  in  NUM_CH*DATA_W  per-channel read data.
- core_rst  out  1  active-high reset to RV32Core.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done on a bad channel.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset values: cmd_ready=1, core_rst=1, everything else 0. FSM goes to IDLE.
- Asserting CPU_RST_N low mid-command aborts the command: no done pulse, dbg_we2 drops immediately, ld and du streams are dropped.
- States: IDLE, LOAD, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, RUN_RST, RUN_EXEC, FIN.
- IDLE: cmd_ready=1 only in IDLE. An accepted command latches op, ch and len.
- Effective length = min(cmd_len, DEPTH) for LOAD/DUMP. Word index i maps to byte address i*(DATA_W/8).
- Bad channel (cmd_ch ≥ NUM_CH on LOAD/DUMP), len=0, or NOP: go straight to FIN, no RAM access. err is raised only for the bad channel.
- FIN: lasts 1 cycle, pulses done, returns to IDLE.
- LOAD: ld_ready=1 while words remain.
  - Each ld handshake registers dbg_a2[ch]=addr, dbg_wd2[ch]=data, dbg_we2[ch]=all-ones for exactly the next cycle.
  - Throughput is 1 word/cycle. ld_valid gaps deassert WE.
  - Go to FIN the cycle after the last write is issued.
  - Unselected channels always have WE=0.
- DUMP:
  - DUMP_ADDR: drive dbg_a2[ch]=addr.
  - DUMP_WAIT: RD_LAT cycles, then capture dbg_rd2[ch] into du_data, with du_addr=addr.
  - DUMP_OUT: hold du_valid, du_data and du_last stable until du_ready, then advance addr.
  - du_last=1 on the final word; after its handshake go to FIN.
  - One read is outstanding at a time. dbg_we2 stays 0 throughout.
- RUN:
  - RUN_RST: core_rst=1 for RST_CYCLES.
  - RUN_EXEC: core_rst=0 for exactly cmd_len cycles (len=0 skips RUN_EXEC).
  - Then core_rst returns to 1 so memory is frozen for DUMP, and go to FIN.
- core_rst is 1 in every state except RUN_EXEC.
- Counters are 32-bit. RUN with cmd_len=0xFFFFFFFF must not wrap early.

Optional Feature:
- Macro: DBG_SEQ_CHECKSUM_EN.
- When defined: checksum clears on acceptance of each LOAD/DUMP. It accumulates the modulo-2^32 sum of the low 32 bits of every ld word written or du word handshaken. It is valid from the done pulse until the next command.
- When undefined: checksum is tied to 0 and no adder is inferred.

Test Plan:
- After reset release, check outputs: cmd_ready=1, core_rst=1, busy=0, dbg_we2=0.
- LOAD ch0 len=3, data 0x11, 0x22, 0x33 with ld_valid continuous -> dbg_a2[0] = 0, 4, 8 on 3 consecutive cycles with WE=4'hF. done pulses 1 cycle after the last write. dbg_we2[1] stays 0.
- DUMP ch0 len=3 with RD_LAT=2 and du_ready held low 5 cycles on the first word -> du_data stable at 0x11 until handshake. Words 0x11, 0x22, 0x33 at du_addr 0, 4, 8. du_last only on 0x33.
- RUN len=100 -> core_rst=1 for 5 cycles, then 0 for exactly 100 cycles, then 1. done pulses once.
- LOAD with cmd_ch=2 (NUM_CH=2) -> no WE activity. done and err pulse together 1 cycle after acceptance.
- CPU_RST_N low during DUMP word 2 -> du_valid=0 and core_rst=1 immediately, no done. A following LOAD works. With DBG_SEQ_CHECKSUM_EN, LOAD of 0x11, 0x22, 0x33 gives checksum=0x66.
